frame_blitter: RTL and testbench

- Writer side of the SRAM framebuffer handshake.
- When the display reader signals a safe window, it takes the SRAM and optionally clears the buffer to a background colour.
- It then draws a list of fixed-size sprites from a sprite ROM into the packed 4-bit-per-pixel framebuffer. Two pixels per byte; high nibble is the left pixel.
- It then hands the SRAM back to the reader through the enable/acknowledge handshake.

---
 rtl/frame_blitter_if.sv | 46 ++++
 rtl/frame_blitter.sv | 209 ++++++++++++++++++++
 tb/tb_frame_blitter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_blitter_if.sv
// frame_blitter_if: groups the reader handshake, sprite command stream,
// sprite ROM port and SRAM pins used by the framebuffer writer.
// master = blitter side, slave = reader/ROM/SRAM side.
interface frame_blitter_if;
    logic        blitterStart;
    logic        ackBack;
    logic        enable;
    logic        acknowladge;
    logic        inControl;
    logic        clear_en;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [6:0]  cmd_x;
    logic [7:0]  cmd_y;
    logic [5:0]  cmd_id;
    logic        cmd_last;
    logic [12:0] spr_addr;
    logic [7:0]  spr_data;
    logic [19:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_out;
    logic        SRAM_DQ_oe;
    logic [15:0] SRAM_DQ_in;
    logic        SRAM_WE_N;
    logic        SRAM_OE_N;
    logic        SRAM_CE_N;
    logic        SRAM_UB_N;
    logic        SRAM_LB_N;

    modport master (
        input  blitterStart, acknowladge, clear_en,
        input  cmd_valid, cmd_x, cmd_y, cmd_id, cmd_last,
        input  spr_data, SRAM_DQ_in,
        output ackBack, enable, inControl, cmd_ready, spr_addr,
        output SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe,
        output SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N
    );

    modport slave (
        output blitterStart, acknowladge, clear_en,
        output cmd_valid, cmd_x, cmd_y, cmd_id, cmd_last,
        output spr_data, SRAM_DQ_in,
        input  ackBack, enable, inControl, cmd_ready, spr_addr,
        input  SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe,
        input  SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N
    );
endinterface

// File: rtl/frame_blitter.sv
// frame_blitter: writer side of the SRAM framebuffer handshake. Takes the
// SRAM when the reader grants it, optionally clears the buffer, draws a list
// of fixed-size sprites (4 bpp, two pixels per byte, high nibble = left
// pixel) and hands the SRAM back.
// Optional macro TRANSPARENCY_EN: pixel index 0 is transparent; each byte is
// read-modify-written, and all-transparent bytes are skipped.
module frame_blitter #(
    parameter logic [19:0] BUF_START   = 20'h00000,
    parameter int          BUF_STRIDE  = 128,
    parameter int          BUF_ROWS    = 120,
    parameter int          SPR_W_BYTES = 8,
    parameter int          SPR_H       = 16,
    parameter logic [3:0]  BG_COLOR    = 4'h0
) (
    input logic             vgaClkIn,
    input logic             reset,
    frame_blitter_if.master bus
);
    localparam logic [19:0] CLR_LAST = 20'(32'(BUF_START) + 32'(BUF_STRIDE * BUF_ROWS) - 32'd1);
    localparam logic [7:0]  C_LAST   = 8'(SPR_W_BYTES - 1);
    localparam logic [7:0]  R_LAST   = 8'(SPR_H - 1);

    typedef enum logic [3:0] {
        IDLE, ACK, CLR_SETUP, CLR_STROBE, CMD_WAIT, ROM_REQ,
        WR_SETUP, WR_STROBE, HANDOFF
`ifdef TRANSPARENCY_EN
        , RD_SETUP, RD_LATCH
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  x_q;
    logic [7:0]  y_q;
    logic [5:0]  id_q;
    logic        last_q;
    logic [7:0]  r_q, c_q;
    logic [19:0] addr_q;
    logic [7:0]  wdata_q;
    logic [8:0]  col, row;
    logic [19:0] wr_addr;
    logic        clipped, last_byte, adv;
    state_t      adv_next;
    logic        unused_dq;
`ifdef TRANSPARENCY_EN
    logic [7:0]  spr_q;
    logic [7:0]  merged;
`endif

    assign col       = 9'(x_q) + 9'(c_q);
    assign row       = 9'(y_q) + 9'(r_q);
    assign clipped   = ({23'd0, col} >= 32'(BUF_STRIDE)) || ({23'd0, row} >= 32'(BUF_ROWS));
    assign wr_addr   = 20'(32'(BUF_START) + 32'(row) * 32'(BUF_STRIDE) + 32'(col));
    assign last_byte = (r_q == R_LAST) && (c_q == C_LAST);
    assign adv_next  = last_byte ? (last_q ? HANDOFF : CMD_WAIT) : ROM_REQ;

    assign bus.spr_addr  = 13'(32'(id_q) * 32'(SPR_H * SPR_W_BYTES)
                             + 32'(r_q) * 32'(SPR_W_BYTES) + 32'(c_q));
    assign bus.SRAM_CE_N = 1'b0;
    assign bus.SRAM_LB_N = 1'b0;
    assign bus.SRAM_UB_N = 1'b1;

`ifdef TRANSPARENCY_EN
    assign merged = {(spr_q[7:4] != 4'h0) ? spr_q[7:4] : bus.SRAM_DQ_in[7:4],
                     (spr_q[3:0] != 4'h0) ? spr_q[3:0] : bus.SRAM_DQ_in[3:0]};
    assign unused_dq = ^bus.SRAM_DQ_in[15:8];
`else
    assign unused_dq = ^bus.SRAM_DQ_in;
`endif

    // State register plus command, counter, address and data latches.
    always_ff @(posedge vgaClkIn) begin
        if (!reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            id_q    <= '0;
            last_q  <= 1'b0;
            r_q     <= '0;
            c_q     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef TRANSPARENCY_EN
            spr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                ACK:        addr_q <= BUF_START;
                CLR_STROBE: if (addr_q != CLR_LAST) addr_q <= addr_q + 20'd1;
                CMD_WAIT: begin
                    if (bus.cmd_valid) begin
                        x_q    <= bus.cmd_x;
                        y_q    <= bus.cmd_y;
                        id_q   <= bus.cmd_id;
                        last_q <= bus.cmd_last;
                        r_q    <= '0;
                        c_q    <= '0;
                    end
                end
                ROM_REQ:    if (!clipped) addr_q <= wr_addr;
`ifdef TRANSPARENCY_EN
                RD_SETUP:   spr_q <= bus.spr_data;
                RD_LATCH:   wdata_q <= merged;
`else
                WR_SETUP:   wdata_q <= bus.spr_data;
`endif
                default: ;
            endcase
            if (adv) begin
                if (c_q == C_LAST) begin
                    c_q <= '0;
                    r_q <= r_q + 8'd1;
                end else begin
                    c_q <= c_q + 8'd1;
                end
            end
        end
    end

    // Next-state decode and all handshake / SRAM strobe outputs.
    always_comb begin
        state_d         = state_q;
        adv             = 1'b0;
        bus.ackBack     = 1'b0;
        bus.enable      = 1'b0;
        bus.inControl   = 1'b1;
        bus.cmd_ready   = 1'b0;
        bus.SRAM_ADDR   = addr_q;
        bus.SRAM_DQ_out = 16'h0000;
        bus.SRAM_DQ_oe  = 1'b0;
        bus.SRAM_WE_N   = 1'b1;
        bus.SRAM_OE_N   = 1'b1;
        case (state_q)
            IDLE: begin
                bus.inControl = 1'b0;
                if (bus.blitterStart) state_d = ACK;
            end
            ACK: begin
                bus.ackBack = 1'b1;
                state_d     = bus.clear_en ? CLR_SETUP : CMD_WAIT;
            end
            CLR_SETUP: begin
                bus.SRAM_DQ_out = {8'h00, BG_COLOR, BG_COLOR};
                bus.SRAM_DQ_oe  = 1'b1;
                state_d         = CLR_STROBE;
            end
            CLR_STROBE: begin
                bus.SRAM_DQ_out = {8'h00, BG_COLOR, BG_COLOR};
                bus.SRAM_DQ_oe  = 1'b1;
                bus.SRAM_WE_N   = 1'b0;
                state_d         = (addr_q == CLR_LAST) ? CMD_WAIT : CLR_SETUP;
            end
            CMD_WAIT: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) state_d = ROM_REQ;
            end
            ROM_REQ: begin
                if (clipped) begin
                    adv     = 1'b1;
                    state_d = adv_next;
                end else begin
`ifdef TRANSPARENCY_EN
                    state_d = RD_SETUP;
`else
                    state_d = WR_SETUP;
`endif
                end
            end
`ifdef TRANSPARENCY_EN
            RD_SETUP: begin
                bus.SRAM_OE_N = 1'b0;
                state_d       = RD_LATCH;
            end
            RD_LATCH: begin
                bus.SRAM_OE_N = 1'b0;
                if (spr_q == 8'h00) begin
                    adv     = 1'b1;
                    state_d = adv_next;
                end else begin
                    state_d = WR_SETUP;
                end
            end
            WR_SETUP: begin
                bus.SRAM_DQ_out = {8'h00, wdata_q};
                bus.SRAM_DQ_oe  = 1'b1;
                state_d         = WR_STROBE;
            end
`else
            WR_SETUP: begin
                bus.SRAM_DQ_out = {8'h00, bus.spr_data};
                bus.SRAM_DQ_oe  = 1'b1;
                state_d         = WR_STROBE;
            end
`endif
            WR_STROBE: begin
                bus.SRAM_DQ_out = {8'h00, wdata_q};
                bus.SRAM_DQ_oe  = 1'b1;
                bus.SRAM_WE_N   = 1'b0;
                adv             = 1'b1;
                state_d         = adv_next;
            end
            HANDOFF: begin
                bus.enable = 1'b1;
                if (bus.acknowladge) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_frame_blitter.sv
// tb_frame_blitter: table-driven sprite commands with a write scoreboard,
// plus hand-written sequences for clear, reset abort and handoff.
`timescale 1ns/1ps
module tb_frame_blitter;
    localparam logic [3:0] BG = 4'h7;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    frame_blitter_if bus();

    frame_blitter #(.BG_COLOR(BG)) dut (
        .vgaClkIn (clk),
        .reset    (reset),
        .bus      (bus)
    );

    typedef struct {
        logic [19:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        int x;
        int y;
        int id;
        bit last;
        int cyc;
        int writes;
    } cmd_t;

    logic [7:0] rom  [0:8191];
    logic [7:0] sram [0:32767];
    wr_t        exp_q[$];
    wr_t        got;
    cmd_t       vec[4];
    cmd_t       spr7;
    int         total = 0;
    int         bad = 0;
    int         ack_cnt = 0;
    int         wr_cnt = 0;
    int         oe_low_cnt = 0;
    bit         sb_on = 1'b1;

    // Sprite ROM with one cycle of read latency.
    always @(posedge clk) bus.spr_data <= rom[bus.spr_addr];

    assign bus.SRAM_DQ_in = {8'h00, sram[bus.SRAM_ADDR[14:0]]};

    // Observe strobes between edges; every WE_N-low cycle is one write.
    always @(negedge clk) begin
        if (bus.ackBack) ack_cnt++;
        if (!bus.SRAM_OE_N) oe_low_cnt++;
        if (!bus.SRAM_WE_N) begin
            wr_cnt++;
            sram[bus.SRAM_ADDR[14:0]] = bus.SRAM_DQ_out[7:0];
            if (sb_on) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL write_unexpected: got addr=%0d data=%h, required no write",
                             bus.SRAM_ADDR, bus.SRAM_DQ_out);
                end else begin
                    got = exp_q.pop_front();
                    if (bus.SRAM_ADDR !== got.addr || bus.SRAM_DQ_out !== {8'h00, got.data}
                        || bus.SRAM_DQ_oe !== 1'b1) begin
                        bad++;
                        $display("[TB] FAIL write_data: got addr=%0d data=%h oe=%b, required addr=%0d data=%h oe=1",
                                 bus.SRAM_ADDR, bus.SRAM_DQ_out, bus.SRAM_DQ_oe, got.addr, {8'h00, got.data});
                    end
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // Expected writes of one sprite, in drawing order.
    function automatic void push_sprite(input int x, input int y, input int id);
        int col;
        int row;
        int a;
        logic [7:0] s;
        logic [7:0] d;
        wr_t w;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 8; c++) begin
                col = x + c;
                row = y + r;
                if (col < 128 && row < 120) begin
                    a = row * 128 + col;
                    s = rom[(id * 128 + r * 8 + c) % 8192];
                    d = s;
`ifdef TRANSPARENCY_EN
                    if (s == 8'h00) continue;
                    d[7:4] = (s[7:4] != 4'h0) ? s[7:4] : sram[a][7:4];
                    d[3:0] = (s[3:0] != 4'h0) ? s[3:0] : sram[a][3:0];
`endif
                    w.addr = 20'(a);
                    w.data = d;
                    exp_q.push_back(w);
                end
            end
        end
    endfunction

    task automatic apply_stimulus(input int idx, input cmd_t v);
        int n;
        int wr0;
        n = 0;
        while (!bus.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_output($sformatf("cmd%0d_ready", idx), 32'(bus.cmd_ready), 32'd1);
        push_sprite(v.x, v.y, v.id);
        wr0 = wr_cnt;
        bus.cmd_x     = 7'(v.x);
        bus.cmd_y     = 8'(v.y);
        bus.cmd_id    = 6'(v.id);
        bus.cmd_last  = v.last;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && !bus.enable && n < 5000) begin
            n++;
            @(negedge clk);
        end
        check_output($sformatf("cmd%0d_cycles", idx), 32'(n), 32'(v.cyc));
        check_output($sformatf("cmd%0d_writes", idx), 32'(wr_cnt - wr0), 32'(v.writes));
        check_output($sformatf("cmd%0d_pending", idx), 32'(exp_q.size()), 32'd0);
        check_output($sformatf("cmd%0d_end_state", idx),
                     {30'd0, bus.enable, bus.cmd_ready}, v.last ? 32'd2 : 32'd1);
    endtask

    task automatic do_handoff(input string tag);
        int hold;
        hold = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.enable && bus.inControl) hold++;
        end
        check_output({tag, "_enable_hold"}, 32'(hold), 32'd5);
        bus.acknowladge = 1'b1;
        @(posedge clk);
        #1;
        bus.acknowladge = 1'b0;
        @(negedge clk);
        check_output({tag, "_enable_drop"}, 32'(bus.enable), 32'd0);
        check_output({tag, "_incontrol_drop"}, 32'(bus.inControl), 32'd0);
    endtask

    task automatic start_frame(input string tag, input logic clr);
        int n;
        bus.clear_en     = clr;
        bus.blitterStart = 1'b1;
        n = 0;
        while (!bus.ackBack && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_output({tag, "_ackback"}, 32'(bus.ackBack), 32'd1);
        check_output({tag, "_ack_incontrol"}, 32'(bus.inControl), 32'd1);
        bus.blitterStart = 1'b0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 8192; i++) rom[i] = 8'(i);
        for (int i = 896; i < 1024; i++) rom[i] = 8'h00;
        rom[896] = 8'h0C;
        for (int i = 0; i < 32768; i++) sram[i] = 8'h00;

`ifdef TRANSPARENCY_EN
        vec[0] = '{x: 2,   y: 3,   id: 1,  last: 1'b0, cyc: 640, writes: 128};
        vec[1] = '{x: 124, y: 118, id: 2,  last: 1'b0, cyc: 158, writes: 7};
        vec[2] = '{x: 0,   y: 0,   id: 63, last: 1'b0, cyc: 640, writes: 128};
        vec[3] = '{x: 127, y: 119, id: 0,  last: 1'b1, cyc: 130, writes: 0};
        spr7   = '{x: 0,   y: 50,  id: 7,  last: 1'b1, cyc: 386, writes: 1};
`else
        vec[0] = '{x: 2,   y: 3,   id: 1,  last: 1'b0, cyc: 384, writes: 128};
        vec[1] = '{x: 124, y: 118, id: 2,  last: 1'b0, cyc: 144, writes: 8};
        vec[2] = '{x: 0,   y: 0,   id: 63, last: 1'b0, cyc: 384, writes: 128};
        vec[3] = '{x: 127, y: 119, id: 0,  last: 1'b1, cyc: 130, writes: 1};
        spr7   = '{x: 0,   y: 50,  id: 7,  last: 1'b1, cyc: 384, writes: 128};
`endif

        bus.blitterStart = 1'b0;
        bus.acknowladge  = 1'b0;
        bus.clear_en     = 1'b0;
        bus.cmd_valid    = 1'b0;
        bus.cmd_x        = '0;
        bus.cmd_y        = '0;
        bus.cmd_id       = '0;
        bus.cmd_last     = 1'b0;

        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst_ackback",   32'(bus.ackBack),    32'd0);
        check_output("rst_enable",    32'(bus.enable),     32'd0);
        check_output("rst_incontrol", 32'(bus.inControl),  32'd0);
        check_output("rst_cmd_ready", 32'(bus.cmd_ready),  32'd0);
        check_output("rst_dq_oe",     32'(bus.SRAM_DQ_oe), 32'd0);
        check_output("rst_strobes",
                     {27'd0, bus.SRAM_WE_N, bus.SRAM_OE_N, bus.SRAM_UB_N, bus.SRAM_CE_N, bus.SRAM_LB_N},
                     32'b11100);
        check_output("rst_sram_addr", 32'(bus.SRAM_ADDR),   32'd0);
        check_output("rst_spr_addr",  32'(bus.spr_addr),    32'd0);
        check_output("rst_dq_out",    32'(bus.SRAM_DQ_out), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] frame 1: clear to background and draw table");
        start_frame("f1", 1'b1);
        for (int i = 0; i < 15360; i++) begin
            got.addr = 20'(i);
            got.data = {BG, BG};
            exp_q.push_back(got);
        end
        n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < 40000) begin
            n++;
            @(negedge clk);
        end
        check_output("clear_cycles",  32'(n), 32'd30720);
        check_output("clear_pending", 32'(exp_q.size()), 32'd0);
        check_output("f1_ack_pulses", 32'(ack_cnt), 32'd1);

        bus.blitterStart = 1'b1;
        repeat (3) @(negedge clk);
        bus.blitterStart = 1'b0;
        check_output("start_ignored_ack",   32'(ack_cnt), 32'd1);
        check_output("start_ignored_ready", 32'(bus.cmd_ready), 32'd1);

        for (int i = 0; i < 4; i++) apply_stimulus(i, vec[i]);
        do_handoff("f1");

        $display("[TB] frame 2: reset during clear");
        sb_on = 1'b0;
        start_frame("f2", 1'b1);
        n = 0;
        while (bus.SRAM_WE_N && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_output("f2_in_strobe", 32'(bus.SRAM_WE_N), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_output("abort_we_n",      32'(bus.SRAM_WE_N),  32'd1);
        check_output("abort_incontrol", 32'(bus.inControl),  32'd0);
        check_output("abort_enable",    32'(bus.enable),     32'd0);
        check_output("abort_dq_oe",     32'(bus.SRAM_DQ_oe), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_output("abort_idle_incontrol", 32'(bus.inControl), 32'd0);
        sb_on = 1'b1;

        $display("[TB] frame 3: no clear, transparency sprite");
        start_frame("f3", 1'b0);
        @(negedge clk);
        check_output("noclear_ready", 32'(bus.cmd_ready), 32'd1);
        sram[50 * 128] = 8'h5A;
        apply_stimulus(4, spr7);
        do_handoff("f3");
        check_output("total_ack_pulses", 32'(ack_cnt), 32'd3);
`ifdef TRANSPARENCY_EN
        check_output("oe_low_cycles", 32'(oe_low_cnt), 32'd786);
`else
        check_output("oe_low_cycles", 32'(oe_low_cnt), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
